// File: rtl/fp13_sort_ctrl.sv
// Burst buffer that bubble-sorts up to DEPTH 13-bit sign/magnitude floats with a single
// shared comparator, then streams them out in ascending order. Optional FP13_SORT_EARLY_EXIT_EN.
module fp13_sort_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [12:0] i_in_data,
  input  logic        i_in_last,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [12:0] o_out_data,
  output logic        o_out_last,
  output logic        o_busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Sign/magnitude ordering: +0 ranks above -0, identical codes never swap.
  function automatic logic fp13_gt(input logic [12:0] a, input logic [12:0] b);
    logic gt_s;
    case ({a[12], b[12]})
      2'b00:   gt_s = (a[11:0] > b[11:0]);
      2'b01:   gt_s = 1'b1;
      2'b10:   gt_s = 1'b0;
      2'b11:   gt_s = (a[11:0] < b[11:0]);
      default: gt_s = 1'b0;
    endcase
    return gt_s;
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   p_q, p_d;
  logic [CW-1:0]   j_q, j_d;
  logic [CW-1:0]   rd_q, rd_d;
  logic [12:0]     buf_q [DEPTH];
`ifdef FP13_SORT_EARLY_EXIT_EN
  logic            swapped_q, swapped_d;
`endif

  logic [IW-1:0]   j_idx_s;
  logic [IW-1:0]   j_nxt_s;
  logic [12:0]     cmp_a_s;
  logic [12:0]     cmp_b_s;
  logic            swap_s;
  logic            accept_s;
  logic            burst_end_s;
  logic [CW-1:0]   count_inc_s;
  logic            pass_end_s;
  logic            final_pass_s;
  logic            rd_last_s;
  logic            load_we_s;
  logic            sort_we_s;

  assign j_idx_s      = j_q[IW-1:0];
  assign j_nxt_s      = j_idx_s + IW'(1);
  assign cmp_a_s      = buf_q[j_idx_s];
  assign cmp_b_s      = buf_q[j_nxt_s];
  assign swap_s       = fp13_gt(cmp_a_s, cmp_b_s);

  assign accept_s     = (state_q == ST_LOAD) && i_in_valid && !i_reset;
  assign burst_end_s  = accept_s && (i_in_last || (count_q == CW'(DEPTH - 1)));
  assign count_inc_s  = count_q + CW'(1);
  assign pass_end_s   = (j_q == (count_q - CW'(2) - p_q));
  assign final_pass_s = (p_q == (count_q - CW'(2)));
  assign rd_last_s    = (rd_q == (count_q - CW'(1)));

  assign load_we_s    = accept_s;
  assign sort_we_s    = (state_q == ST_SORT) && swap_s && !i_reset;

  // Next-state logic for the LOAD/SORT/DRAIN sequencer and its counters.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    p_d     = p_q;
    j_d     = j_q;
    rd_d    = rd_q;
`ifdef FP13_SORT_EARLY_EXIT_EN
    swapped_d = swapped_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (accept_s) begin
          count_d = count_inc_s;
          if (burst_end_s) begin
            p_d  = CW'(0);
            j_d  = CW'(0);
            rd_d = CW'(0);
`ifdef FP13_SORT_EARLY_EXIT_EN
            swapped_d = 1'b0;
`endif
            if (count_inc_s >= CW'(2)) begin
              state_d = ST_SORT;
            end else begin
              state_d = ST_DRAIN;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_SORT: begin
        if (pass_end_s) begin
          if (final_pass_s) begin
            state_d = ST_DRAIN;
            rd_d    = CW'(0);
          end else begin
`ifdef FP13_SORT_EARLY_EXIT_EN
            // A pass that moved nothing proves the buffer is already ordered.
            if (!(swapped_q || swap_s)) begin
              state_d = ST_DRAIN;
              rd_d    = CW'(0);
            end else begin
              p_d       = p_q + CW'(1);
              j_d       = CW'(0);
              swapped_d = 1'b0;
            end
`else
            p_d = p_q + CW'(1);
            j_d = CW'(0);
`endif
          end
        end else begin
          j_d = j_q + CW'(1);
`ifdef FP13_SORT_EARLY_EXIT_EN
          swapped_d = swapped_q || swap_s;
`endif
        end
      end
      ST_DRAIN: begin
        if (i_out_ready) begin
          if (rd_last_s) begin
            state_d = ST_LOAD;
            count_d = CW'(0);
            rd_d    = CW'(0);
          end else begin
            rd_d = rd_q + CW'(1);
          end
        end else begin
          rd_d = rd_q;
        end
      end
      default: begin
        state_d = ST_LOAD;
        count_d = CW'(0);
      end
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_LOAD;
      count_q <= CW'(0);
      p_q     <= CW'(0);
      j_q     <= CW'(0);
      rd_q    <= CW'(0);
`ifdef FP13_SORT_EARLY_EXIT_EN
      swapped_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      p_q     <= p_d;
      j_q     <= j_d;
      rd_q    <= rd_d;
`ifdef FP13_SORT_EARLY_EXIT_EN
      swapped_q <= swapped_d;
`endif
    end
  end

  // Element storage: written on input accept or on a compare/swap; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (load_we_s) begin
      buf_q[count_q[IW-1:0]] <= i_in_data;
    end else if (sort_we_s) begin
      buf_q[j_idx_s] <= cmp_b_s;
      buf_q[j_nxt_s] <= cmp_a_s;
    end
  end

  assign o_in_ready  = (state_q == ST_LOAD) && !i_reset;
  assign o_out_valid = (state_q == ST_DRAIN);
  assign o_out_data  = (state_q == ST_DRAIN) ? buf_q[rd_q[IW-1:0]] : 13'h0000;
  assign o_out_last  = (state_q == ST_DRAIN) && rd_last_s;
  assign o_busy      = (state_q == ST_SORT) || (state_q == ST_DRAIN);

endmodule
